// File: rtl/gcn_input_memory.sv
// Weight/feature line store for the GCN transform block: filled by a serial
// element stream, then read one full line per cycle with one cycle of latency.
module gcn_input_memory #(
  parameter int WEIGHT_ROWS   = 96,
  parameter int WEIGHT_COLS   = 3,
  parameter int FEATURE_ROWS  = 6,
  parameter int ELEM_WIDTH    = 5,
  parameter int ADDRESS_WIDTH = 13,
  parameter int FEATURE_BASE  = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [ELEM_WIDTH-1:0]    load_data,
  output logic                     load_ready,
  output logic                     load_done,
  input  logic                     enable_read,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  output logic [ELEM_WIDTH-1:0]    read_data [0:WEIGHT_ROWS-1],
  output logic                     read_valid,
  output logic                     addr_error
);

  localparam int LINES = WEIGHT_COLS + FEATURE_ROWS;
  localparam int N     = LINES * WEIGHT_ROWS;
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int LW    = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int PW    = (WEIGHT_ROWS > 1) ? $clog2(WEIGHT_ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] wline_q, wline_d;
  logic [PW-1:0] wpos_q, wpos_d;
  logic          accept_s;
  logic          mapped_s;
  logic          service_s;
  logic [LW-1:0] rline_s;
  logic          read_valid_q;
  logic          addr_error_q;

  logic [ELEM_WIDTH-1:0] mem_q [0:LINES-1][0:WEIGHT_ROWS-1];

  // Line/position counters track the flat counter so no divider is needed.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wline_d  = wline_q;
    wpos_d   = wpos_q;
    accept_s = 1'b0;
    if (load_start) begin
      state_d = LOAD;
      cnt_d   = '0;
      wline_d = '0;
      wpos_d  = '0;
    end else if ((state_q == LOAD) && load_valid) begin
      accept_s = 1'b1;
      if (cnt_q == CW'(N - 1)) begin
        state_d = READY;
      end else begin
        cnt_d = cnt_q + CW'(1);
        if (wpos_q == PW'(WEIGHT_ROWS - 1)) begin
          wpos_d  = '0;
          wline_d = wline_q + LW'(1);
        end else begin
          wpos_d = wpos_q + PW'(1);
        end
      end
    end else begin
      accept_s = 1'b0;
    end
  end

  always_comb begin
    mapped_s = 1'b0;
    rline_s  = '0;
    if (read_address < ADDRESS_WIDTH'(WEIGHT_COLS)) begin
      mapped_s = 1'b1;
      rline_s  = LW'(read_address);
    end else if ((read_address >= ADDRESS_WIDTH'(FEATURE_BASE)) &&
                 (read_address <  ADDRESS_WIDTH'(FEATURE_BASE + FEATURE_ROWS))) begin
      mapped_s = 1'b1;
      rline_s  = LW'(read_address - ADDRESS_WIDTH'(FEATURE_BASE)) + LW'(WEIGHT_COLS);
    end else begin
      mapped_s = 1'b0;
    end
    service_s = enable_read && (state_q == READY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wline_q <= '0;
      wpos_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wline_q <= wline_d;
      wpos_q  <= wpos_d;
    end
  end

  // Storage keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wline_q][wpos_q] <= load_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_valid_q <= 1'b0;
      addr_error_q <= 1'b0;
      for (int i = 0; i < WEIGHT_ROWS; i++) read_data[i] <= '0;
    end else begin
      read_valid_q <= service_s;
      addr_error_q <= service_s && !mapped_s;
      if (service_s && mapped_s) begin
        for (int i = 0; i < WEIGHT_ROWS; i++) read_data[i] <= mem_q[rline_s][i];
      end else if (service_s) begin
        for (int i = 0; i < WEIGHT_ROWS; i++) read_data[i] <= '0;
      end
    end
  end

  assign load_ready = (state_q == LOAD);
  assign load_done  = (state_q == READY);
  assign read_valid = read_valid_q;
  assign addr_error = addr_error_q;

endmodule
